ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/ram_arbiter_rr_select.sv | 28 ++
 rtl/ram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, RAM handshake state and the RAM arbiter FSM state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    WORD0,
    WORD1,
    ABORT
  } arb_state_t;

  // Load value returned to a requester whose access was killed by the watchdog.
  localparam word_t ARB_ABORT_LOAD = 32'hBAD1BAD1;
endpackage

// File: rtl/ram_arbiter_rr_select.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping N-1 to 0. Purely combinational.
module rr_select #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   off;

  // rot[k] is requester (ptr + k) mod N, so the lowest set bit is the winner's distance from ptr.
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr +: N];

  always_comb begin
    valid = |req;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = W'(k);
    end
  end

  assign idx = ptr + off;
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters, single words or 2-word bursts.
// Define RAM_ARB_TIMEOUT_EN to add the watchdog that aborts accesses stuck for TIMEOUT cycles.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NREQ-1:0]           req_ren,
  input  logic [NREQ-1:0]           req_wen,
  input  logic [NREQ-1:0]           req_burst,
  input  word_t [NREQ-1:0]          req_addr,
  input  word_t [NREQ-1:0]          req_store,
  output logic [NREQ-1:0]           req_wait,
  output word_t [NREQ-1:0]          req_load,
  output logic                      ramREN,
  output logic                      ramWEN,
  output word_t                     ramaddr,
  output word_t                     ramstore,
  input  word_t                     ramload,
  input  ramstate_t                 ramstate,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int IW = $clog2(NREQ);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] grant_reg, grant_next;
  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  logic          burst_reg, burst_next;

  logic [NREQ-1:0] req_active;
  logic            sel_valid;
  logic [IW-1:0]   sel_idx;

  logic  g_ren, g_wen, g_act;
  word_t g_addr;

  assign req_active = req_ren | req_wen;

  rr_select #(.N(NREQ)) u_rr_select (
    .req   (req_active),
    .ptr   (rr_ptr_reg),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

`ifdef RAM_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wdog_reg, wdog_next;
  logic           timeout_err_reg;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      burst_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      burst_reg  <= burst_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    burst_next  = burst_reg;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    req_wait    = '1;
    req_load    = '0;
    g_ren       = req_ren[grant_reg];
    g_wen       = req_wen[grant_reg];
    g_act       = g_ren | g_wen;
    g_addr      = req_addr[grant_reg];

    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          grant_next = sel_idx;
          burst_next = req_burst[sel_idx];
          state_next = WORD0;
        end
      end

      WORD0, WORD1: begin
        // A requester that withdraws loses the port at once; its half-done burst is simply dropped.
        if (!g_act) begin
          state_next = IDLE;
        end else begin
          ramWEN   = g_wen;
          ramREN   = ~g_wen;
          ramstore = g_wen ? req_store[grant_reg] : '0;
          if (state_reg == WORD1)
            ramaddr = {g_addr[31:3], 3'b100};
          else if (burst_reg)
            ramaddr = {g_addr[31:3], 3'b000};
          else
            ramaddr = g_addr;

          if (ramstate == ACCESS) begin
            req_wait[grant_reg] = 1'b0;
            req_load[grant_reg] = ramload;
            if (state_reg == WORD0 && burst_reg) begin
              state_next = WORD1;
            end else begin
              state_next  = IDLE;
              rr_ptr_next = grant_reg + 1'b1;
            end
          end
`ifdef RAM_ARB_TIMEOUT_EN
          else if (wdog_reg == WDW'(TIMEOUT - 1)) begin
            state_next = ABORT;
          end
`endif
        end
      end

`ifdef RAM_ARB_TIMEOUT_EN
      ABORT: begin
        req_wait[grant_reg] = 1'b0;
        req_load[grant_reg] = ARB_ABORT_LOAD;
        rr_ptr_next         = grant_reg + 1'b1;
        state_next          = IDLE;
      end
`endif

      default: state_next = IDLE;
    endcase
  end

`ifdef RAM_ARB_TIMEOUT_EN
  // Counts consecutive stalled cycles of the current word; any completion or exit clears it.
  always_comb begin
    wdog_next = '0;
    if ((state_reg == WORD0 || state_reg == WORD1) && g_act && ramstate != ACCESS)
      wdog_next = wdog_reg + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdog_reg        <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      wdog_reg        <= wdog_next;
      timeout_err_reg <= timeout_err_reg | (state_next == ABORT);
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  assign grant_id = grant_reg;
  assign busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: transaction-level reference model checked every cycle plus literal pins.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int N = 4;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [N-1:0]  req_ren, req_wen, req_burst;
  word_t [N-1:0] req_addr, req_store;
  logic [N-1:0]  req_wait;
  word_t [N-1:0] req_load;
  logic          ramREN, ramWEN;
  word_t         ramaddr, ramstore, ramload;
  ramstate_t     ramstate;
  logic [1:0]    grant_id;
  logic          busy, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  ram_arbiter #(.NREQ(N), .TIMEOUT(64)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .req_ren     (req_ren),
    .req_wen     (req_wen),
    .req_burst   (req_burst),
    .req_addr    (req_addr),
    .req_store   (req_store),
    .req_wait    (req_wait),
    .req_load    (req_load),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramload     (ramload),
    .ramstate    (ramstate),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: who owns the port, which word of the transfer, and where round-robin resumes.
  int m_owner, m_word, m_ptr, m_grant, mi;
  bit m_burst;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_owner = -1;
      m_word  = 0;
      m_ptr   = 0;
      m_grant = 0;
      m_burst = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        mi = (m_ptr + k) % N;
        if (m_owner < 0 && (req_ren[mi] || req_wen[mi])) begin
          m_owner = mi;
          m_grant = mi;
          m_word  = 0;
          m_burst = req_burst[mi];
        end
      end
    end else if (!(req_ren[m_owner] || req_wen[m_owner])) begin
      $display("requester %0d withdrew during word %0d", m_owner, m_word);
      m_owner = -1;
    end else if (ramstate == ACCESS) begin
      $display("requester %0d %s word %0d done", m_owner, req_wen[m_owner] ? "write" : "read", m_word);
      if (m_word == 0 && m_burst) begin
        m_word = 1;
      end else begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  logic [N-1:0]  e_wait;
  word_t [N-1:0] e_load;
  logic          e_ren, e_wen;
  word_t         e_addr, e_store, e_base;

  always @(negedge CLK) begin
    e_wait  = '1;
    e_load  = '0;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_addr  = '0;
    e_store = '0;
    if (m_owner >= 0 && (req_ren[m_owner] || req_wen[m_owner])) begin
      e_base  = req_addr[m_owner] & ~32'h7;
      e_wen   = req_wen[m_owner];
      e_ren   = !e_wen;
      e_store = e_wen ? req_store[m_owner] : 32'h0;
      if (m_word == 1)  e_addr = e_base + 32'd4;
      else if (m_burst) e_addr = e_base;
      else              e_addr = req_addr[m_owner];
      if (ramstate == ACCESS) begin
        e_wait[m_owner] = 1'b0;
        e_load[m_owner] = ramload;
      end
    end
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("req_wait", req_wait, e_wait);
    for (int k = 0; k < N; k++) chk("req_load", req_load[k], e_load[k]);
    chk("busy", busy, m_owner >= 0);
    chk("grant_id", grant_id, m_grant);
    chk("timeout_err", timeout_err, 1'b0);
  end

  int grant_q[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    req_ren   = '0;
    req_wen   = '0;
    req_burst = '0;
    req_addr  = '0;
    req_store = '0;
    ramload   = '0;
    ramstate  = FREE;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_wait", req_wait, 4'hF);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_strobes", {ramREN, ramWEN}, 2'b00);
    nRST = 1'b1;
    cyc();

    // Single read by requester 2, two BUSY cycles before ACCESS.
    req_addr[2] = 32'h100;
    req_ren[2]  = 1'b1;
    ramstate    = BUSY;
    cyc();
    chk("rd_grant", grant_id, 2'd2);
    chk("rd_wait_busy", req_wait[2], 1'b1);
    cyc();
    cyc();
    ramstate = ACCESS;
    ramload  = 32'hDEADBEEF;
    #1;
    chk("rd_wait_pulse", req_wait, 4'b1011);
    chk("rd_load", req_load[2], 32'hDEADBEEF);
    chk("rd_addr", ramaddr, 32'h100);
    chk("rd_ren", ramREN, 1'b1);
    cyc();
    req_ren  = '0;
    ramstate = FREE;
    req_ren  = 4'b1001;
    cyc();
    chk("rd_rr_ptr3", grant_id, 2'd3);
    req_ren = '0;
    cyc();

    // Burst write by requester 1 at 0x204; burst changed mid-transfer must be ignored.
    req_addr[1]  = 32'h204;
    req_store[1] = 32'h12345678;
    req_wen[1]   = 1'b1;
    req_burst[1] = 1'b1;
    cyc();
    chk("bw_grant", grant_id, 2'd1);
    chk("bw_addr0", ramaddr, 32'h200);
    chk("bw_wen0", ramWEN, 1'b1);
    chk("bw_store", ramstore, 32'h12345678);
    req_burst[1] = 1'b0;
    ramstate     = ACCESS;
    #1;
    chk("bw_addr0_latched", ramaddr, 32'h200);
    chk("bw_pulse0", req_wait, 4'b1101);
    cyc();
    chk("bw_addr1", ramaddr, 32'h204);
    chk("bw_wen1", ramWEN, 1'b1);
    chk("bw_pulse1", req_wait, 4'b1101);
    cyc();
    req_wen  = '0;
    ramstate = FREE;
    chk("bw_done", busy, 1'b0);

    // Simultaneous read and write on requester 0: the write wins.
    req_addr[0]  = 32'h40;
    req_store[0] = 32'hA5A5A5A5;
    req_ren[0]   = 1'b1;
    req_wen[0]   = 1'b1;
    ramstate     = BUSY;
    cyc();
    chk("rw_grant", grant_id, 2'd0);
    chk("rw_wen", ramWEN, 1'b1);
    chk("rw_ren", ramREN, 1'b0);
    ramstate = ACCESS;
    cyc();
    req_ren = '0;
    req_wen = '0;

    // Requester 3 moves the pointer back to 0, then all four compete.
    req_ren[3] = 1'b1;
    cyc();
    cyc();
    req_ren = '0;
    for (int k = 0; k < N; k++) req_addr[k] = 32'h1000 + 32'(k * 16);
    req_ren = '1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (busy) grant_q.push_back(int'(grant_id));
    end
    chk("fair_count", grant_q.size(), 5);
    for (int k = 0; k < 5 && k < grant_q.size(); k++) chk("fair_order", grant_q[k], exp_order[k]);
    req_ren  = '0;
    ramstate = FREE;
    cyc();

    // Burst read by requester 2 abandoned in its second word.
    req_addr[2]  = 32'h30C;
    req_burst[2] = 1'b1;
    req_ren[2]   = 1'b1;
    ramstate     = ACCESS;
    cyc();
    chk("drop_addr0", ramaddr, 32'h308);
    cyc();
    chk("drop_addr1", ramaddr, 32'h30C);
    req_ren[2] = 1'b0;
    #1;
    chk("drop_no_pulse", req_wait, 4'hF);
    chk("drop_ren", ramREN, 1'b0);
    cyc();
    chk("drop_idle", busy, 1'b0);
    req_ren  = 4'b1010;
    ramstate = BUSY;
    cyc();
    chk("drop_ptr_kept", grant_id, 2'd1);
    chk("rst_pre_ren", ramREN, 1'b1);

    // Asynchronous reset while in WORD0 kills the strobes immediately.
    nRST = 1'b0;
    #1;
    chk("rst_mid_ren", ramREN, 1'b0);
    chk("rst_mid_wait", req_wait, 4'hF);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_grant", grant_id, 2'd0);
    req_ren  = '0;
    ramstate = FREE;
    cyc();
    nRST = 1'b1;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
